uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx_pkg.sv | 15 +
 rtl/uart_tx_fifo.sv | 55 +++++
 rtl/uart_tx.sv | 122 ++++++++++++
 tb/tb_uart_tx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: bus width, defaults, FSM encoding.
package uart_tx_pkg;

    localparam int REG_BUS_W         = 32;
    localparam int UART_CLKS_PER_BIT = 434;
    localparam int UART_FIFO_DEPTH   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; pointers wrap naturally at DEPTH.
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        full,
    output logic        empty,
    output logic [AW:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a byte FIFO; txd_o is registered one cycle
// behind the FSM state so the line never glitches.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = UART_FIFO_DEPTH,
    localparam int AW          = $clog2(FIFO_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_BUS_W-1:0] uart_data_i,
    input  logic                 uart_en_i,
    output logic                 txd_o,
    output logic                 full_o,
    output logic                 stallreq_o,
    output logic                 busy_o,
    output logic                 overflow_o,
    output logic [AW:0]          count_o
);

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    tx_state_e   state;
    logic [15:0] baud;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [7:0]  head;
    logic        fifo_empty;
    logic        baud_done;
    logic        pop;
    logic        push;
    logic        unused_upper;

    assign unused_upper = ^uart_data_i[REG_BUS_W-1:8];
    assign baud_done    = baud == BAUD_LAST;
    assign push         = uart_en_i && !rst;
    assign pop          = !fifo_empty &&
                          ((state == IDLE) ||
                           (state == STOP && baud_done));

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (uart_data_i[7:0]),
        .rdata (head),
        .full  (full_o),
        .empty (fifo_empty),
        .count (count_o)
    );

    assign stallreq_o = full_o;
    assign busy_o     = (state != IDLE) || (count_o != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            baud       <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            txd_o      <= 1'b1;
            overflow_o <= 1'b0;
        end else begin
            if (uart_en_i && full_o) begin
                overflow_o <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    txd_o <= 1'b1;
                    if (pop) begin
                        shreg <= head;
                        baud  <= '0;
                        state <= START;
                    end
                end
                START: begin
                    txd_o <= 1'b0;
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    txd_o <= shreg[bit_idx];
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    txd_o <= 1'b1;
                    if (baud_done) begin
                        baud <= '0;
                        // chain straight into the next frame, no idle gap
                        if (pop) begin
                            shreg <= head;
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: scoreboard of written bytes compared
// against a serial-line receiver model, plus timing and flag checks.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] uart_data = '0;
    logic        uart_en = 1'b0;
    logic        txd;
    logic        full;
    logic        stallreq;
    logic        busy;
    logic        overflow;
    logic [4:0]  count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         starts[$];

    bit         mon_active = 1'b0;
    int         mon_t = 0;
    logic [7:0] rx = '0;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_data_i (uart_data),
        .uart_en_i   (uart_en),
        .txd_o       (txd),
        .full_o      (full),
        .stallreq_o  (stallreq),
        .busy_o      (busy),
        .overflow_o  (overflow),
        .count_o     (count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serial receiver: sample mid-bit on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (txd === 1'b0) begin
                mon_active = 1'b1;
                mon_t = 0;
                starts.push_back(cyc);
            end
        end else begin
            mon_t++;
            if (mon_t == 2) begin
                check("start_bit", txd, 1'b0);
            end else if (mon_t >= 6 && mon_t <= 34 && (mon_t - 6) % 4 == 0) begin
                rx[(mon_t - 6) / 4] = txd;
            end else if (mon_t == 38) begin
                check("stop_bit", txd, 1'b1);
                if (exp_q.size() > 0) begin
                    check("rx_byte", rx, exp_q.pop_front());
                end else begin
                    check("rx_unexpected", exp_q.size(), 1);
                end
                mon_active = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] d, input bit accept);
        uart_data = d;
        uart_en = 1'b1;
        if (accept) exp_q.push_back(d[7:0]);
        tick();
        uart_en = 1'b0;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (!busy && !mon_active) break;
            tick();
        end
        tick();
        tick();
        check("drain_busy", busy, 1'b0);
        check("drain_sb", exp_q.size(), 0);
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_txd", txd, 1'b1);
        check("rst_count", count, 0);
        check("rst_full", full, 1'b0);
        check("rst_stall", stallreq, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        tick();

        // single frame: latency and busy window
        wr(32'h0000_0055, 1'b1);
        check("e0_count", count, 1);
        check("e0_txd", txd, 1'b1);
        tick();
        check("e1_txd", txd, 1'b1);
        check("e1_count", count, 0);
        check("e1_busy", busy, 1'b1);
        tick();
        check("e2_txd_start", txd, 1'b0);
        repeat (38) tick();
        check("e40_busy", busy, 1'b1);
        tick();
        check("e41_busy", busy, 1'b0);
        drain(100);

        // upper bits ignored
        wr(32'hDEAD_BEA5, 1'b1);
        drain(100);

        // back-to-back frames
        starts.delete();
        wr(32'h01, 1'b1);
        wr(32'h80, 1'b1);
        drain(150);
        check("b2b_frames", starts.size(), 2);
        if (starts.size() == 2) begin
            check("b2b_gap", starts[1] - starts[0], 40);
        end

        // fill to full, one write dropped
        for (int i = 0; i < 18; i++) begin
            wr({$urandom_range(0, 255), 16'h0, 8'(8'h30 + i)}, i < 17);
        end
        check("fill_count", count, 16);
        check("fill_full", full, 1'b1);
        check("fill_stall", stallreq, 1'b1);
        check("fill_ovf", overflow, 1'b1);
        drain(900);
        check("ovf_sticky", overflow, 1'b1);

        // reset during data bit 3
        wr(32'h3C, 1'b1);
        repeat (18) tick();
        rst = 1'b1;
        uart_en = 1'b1;
        uart_data = 32'h77;
        exp_q.delete();
        tick();
        rst = 1'b0;
        uart_en = 1'b0;
        check("mid_rst_txd", txd, 1'b1);
        check("mid_rst_count", count, 0);
        check("mid_rst_ovf", overflow, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        tick();
        wr(32'h96, 1'b1);
        drain(100);

        // write lands on the STOP pop edge with one byte queued
        wr(32'hA1, 1'b1);
        repeat (4) tick();
        wr(32'hB2, 1'b1);
        check("pre_pop_count", count, 1);
        repeat (35) tick();
        wr(32'hC3, 1'b1);
        check("pop_push_count", count, 1);
        check("pop_push_busy", busy, 1'b1);
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
